// File: rtl/VX_tb_common_pkg.sv
// Shared types and constants for the tb memory subsystem.
package VX_tb_common_pkg;

  typedef logic [0:0] arb_state_t;

  localparam arb_state_t ARB_IDLE = 1'b0;
  localparam arb_state_t ARB_HOLD = 1'b1;

  localparam logic ARB_PORT_LDR = 1'b0;
  localparam logic ARB_PORT_CHK = 1'b1;

  localparam logic MEM_RW_READ  = 1'b0;
  localparam logic MEM_RW_WRITE = 1'b1;

endpackage

// File: rtl/VX_mem_bus_if.sv
// Valid/ready memory bus: request channel (rw/addr/data/tag) and read-response channel.
interface VX_mem_bus_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int TAG_WIDTH  = 8
) ();

  logic                  req_valid;
  logic                  req_rw;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_data;
  logic [TAG_WIDTH-1:0]  req_tag;
  logic                  req_ready;

  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [TAG_WIDTH-1:0]  rsp_tag;
  logic                  rsp_ready;

  modport master (
    output req_valid, req_rw, req_addr, req_data, req_tag,
    input  req_ready,
    input  rsp_valid, rsp_data, rsp_tag,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_data, req_tag,
    output req_ready,
    output rsp_valid, rsp_data, rsp_tag,
    input  rsp_ready
  );

endinterface

// File: rtl/vx_tb_arb_src_fifo.sv
// Depth x 1-bit FIFO recording which port issued each outstanding read.
module vx_tb_arb_src_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     push_src,
  input  logic                     pop,
  output logic                     head_src,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [DEPTH-1:0] src_q;
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign full     = (count_q == (PtrW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign head_src = src_q[rd_ptr_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      src_q[wr_ptr_q] <= push_src;
    end
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PtrW+1)'(1);
        2'b01:   count_q <= count_q - (PtrW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/vx_tb_mem_arbiter.sv
// Two-port loader/checker arbiter onto the memory-model bus with read-response routing.
// Define TB_MEM_ARB_LDR_PRIO_EN for fixed loader priority instead of round-robin.
module vx_tb_mem_arbiter
  import VX_tb_common_pkg::*;
#(
  parameter int unsigned MAX_PENDING = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  VX_mem_bus_if.slave                   ldr_bus_if,
  VX_mem_bus_if.slave                   chk_bus_if,
  VX_mem_bus_if.master                  mem_bus_if,
  output logic                          arb_err,
  output logic [$clog2(MAX_PENDING):0]  pending_cnt
);

  arb_state_t state_q, state_d;
  logic       rr_ptr_q, rr_ptr_d;
  logic       hold_port_q, hold_port_d;
  logic       arb_err_q;

  logic fifo_full, fifo_empty, fifo_head;
  logic ldr_cand, chk_cand;
  logic gnt_valid, gnt_port;
  logic req_fire, rsp_fire;

  // Reads are held off while the source queue is full, even if it pops this cycle.
  assign ldr_cand = ldr_bus_if.req_valid && !(ldr_bus_if.req_rw == MEM_RW_READ && fifo_full);
  assign chk_cand = chk_bus_if.req_valid && !(chk_bus_if.req_rw == MEM_RW_READ && fifo_full);

  always_comb begin
    gnt_valid = 1'b0;
    gnt_port  = ARB_PORT_LDR;
    if (state_q == ARB_HOLD) begin
      gnt_port  = hold_port_q;
      gnt_valid = (hold_port_q == ARB_PORT_CHK) ? chk_bus_if.req_valid : ldr_bus_if.req_valid;
    end else begin
      gnt_valid = ldr_cand || chk_cand;
`ifdef TB_MEM_ARB_LDR_PRIO_EN
      gnt_port  = ldr_cand ? ARB_PORT_LDR : ARB_PORT_CHK;
`else
      gnt_port  = (ldr_cand && chk_cand) ? rr_ptr_q : chk_cand;
`endif
    end
  end

  assign mem_bus_if.req_valid = reset && gnt_valid;
  assign mem_bus_if.req_rw    = gnt_port ? chk_bus_if.req_rw   : ldr_bus_if.req_rw;
  assign mem_bus_if.req_addr  = gnt_port ? chk_bus_if.req_addr : ldr_bus_if.req_addr;
  assign mem_bus_if.req_data  = gnt_port ? chk_bus_if.req_data : ldr_bus_if.req_data;
  assign mem_bus_if.req_tag   = gnt_port ? chk_bus_if.req_tag  : ldr_bus_if.req_tag;

  assign ldr_bus_if.req_ready = reset && gnt_valid && (gnt_port == ARB_PORT_LDR)
                                && mem_bus_if.req_ready;
  assign chk_bus_if.req_ready = reset && gnt_valid && (gnt_port == ARB_PORT_CHK)
                                && mem_bus_if.req_ready;

  assign req_fire = mem_bus_if.req_valid && mem_bus_if.req_ready;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    hold_port_d = hold_port_q;
    if (req_fire) begin
      state_d = ARB_IDLE;
`ifdef TB_MEM_ARB_LDR_PRIO_EN
      rr_ptr_d = 1'b0;
`else
      rr_ptr_d = ~gnt_port;
`endif
    end else if (gnt_valid) begin
      state_d     = ARB_HOLD;
      hold_port_d = gnt_port;
    end else begin
      // Also covers a held requester dropping valid without a handshake.
      state_d = ARB_IDLE;
    end
  end

  // Responses follow the head of the source queue; with an empty queue they are swallowed.
  assign ldr_bus_if.rsp_valid = reset && mem_bus_if.rsp_valid && !fifo_empty
                                && (fifo_head == ARB_PORT_LDR);
  assign chk_bus_if.rsp_valid = reset && mem_bus_if.rsp_valid && !fifo_empty
                                && (fifo_head == ARB_PORT_CHK);
  assign ldr_bus_if.rsp_data  = mem_bus_if.rsp_data;
  assign ldr_bus_if.rsp_tag   = mem_bus_if.rsp_tag;
  assign chk_bus_if.rsp_data  = mem_bus_if.rsp_data;
  assign chk_bus_if.rsp_tag   = mem_bus_if.rsp_tag;
  assign mem_bus_if.rsp_ready = reset && (fifo_empty ||
                                (fifo_head == ARB_PORT_CHK ? chk_bus_if.rsp_ready
                                                           : ldr_bus_if.rsp_ready));

  assign rsp_fire = mem_bus_if.rsp_valid && mem_bus_if.rsp_ready;

  vx_tb_arb_src_fifo #(
    .DEPTH (MAX_PENDING)
  ) u_src_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (req_fire && mem_bus_if.req_rw == MEM_RW_READ),
    .push_src (gnt_port),
    .pop      (rsp_fire && !fifo_empty),
    .head_src (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (pending_cnt)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ARB_IDLE;
      rr_ptr_q    <= 1'b0;
      hold_port_q <= ARB_PORT_LDR;
      arb_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      hold_port_q <= hold_port_d;
      if (rsp_fire && fifo_empty) arb_err_q <= 1'b1;
    end
  end

  assign arb_err = arb_err_q;

endmodule

// File: tb/tb_vx_tb_mem_arbiter.sv
// Randomized + directed bench for vx_tb_mem_arbiter against a queue-based reference model.
module tb_vx_tb_mem_arbiter;
  import VX_tb_common_pkg::*;

  localparam int MAXP = 4;

  logic clk = 1'b0;
  logic reset;
  logic [2:0] pending_cnt;
  logic arb_err;

  always #5 clk = ~clk;

  VX_mem_bus_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .TAG_WIDTH(8)) ldr_if ();
  VX_mem_bus_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .TAG_WIDTH(8)) chk_if ();
  VX_mem_bus_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .TAG_WIDTH(8)) mem_if ();

  vx_tb_mem_arbiter #(
    .MAX_PENDING (MAXP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ldr_bus_if  (ldr_if),
    .chk_bus_if  (chk_if),
    .mem_bus_if  (mem_if),
    .arb_err     (arb_err),
    .pending_cnt (pending_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Requester stimulus, indexed by port (0 = loader, 1 = checker).
  bit          rq_v[2];
  logic        rq_rw[2];
  logic [31:0] rq_addr[2];
  logic [63:0] rq_data[2];
  logic [7:0]  rq_tag[2];
  bit          p_rsp_rdy[2];
  bit          m_req_rdy;
  bit          m_rsp_v;
  logic [63:0] m_rsp_d;
  logic [7:0]  m_rsp_t;

  // Reference model: queue of read sources, preferred port, port locked awaiting handshake.
  bit m_q[$];
  int m_pref;
  int m_lock;
  bit m_err;

  int obs_gnt;
  int obs_rsp;

  task automatic issue(input int p, input logic rw, input logic [31:0] a);
    if (!rq_v[p]) begin
      rq_v[p]    = 1'b1;
      rq_rw[p]   = rw;
      rq_addr[p] = a;
      rq_data[p] = {$urandom, $urandom};
      rq_tag[p]  = {p[0], 7'($urandom)};  // tag MSB identifies the source port
    end
  endtask

  task automatic apply();
    ldr_if.req_valid = rq_v[0];
    ldr_if.req_rw    = rq_rw[0];
    ldr_if.req_addr  = rq_addr[0];
    ldr_if.req_data  = rq_data[0];
    ldr_if.req_tag   = rq_tag[0];
    ldr_if.rsp_ready = p_rsp_rdy[0];
    chk_if.req_valid = rq_v[1];
    chk_if.req_rw    = rq_rw[1];
    chk_if.req_addr  = rq_addr[1];
    chk_if.req_data  = rq_data[1];
    chk_if.req_tag   = rq_tag[1];
    chk_if.rsp_ready = p_rsp_rdy[1];
    mem_if.req_ready = m_req_rdy;
    mem_if.rsp_valid = m_rsp_v;
    mem_if.rsp_data  = m_rsp_d;
    mem_if.rsp_tag   = m_rsp_t;
  endtask

  // One clock: drive, check combinational outputs against the model, advance the model.
  task automatic cycle();
    int g;
    int h;
    bit c0, c1, full, pop, hs;
    apply();
    #1;
    obs_gnt = mem_if.req_valid ? int'(mem_if.req_tag[7]) : -1;
    obs_rsp = ldr_if.rsp_valid ? 0 : (chk_if.rsp_valid ? 1 : -1);
    if (!reset) begin
      check_eq("rst_req_valid", mem_if.req_valid, 1'b0);
      check_eq("rst_rsp_ready", mem_if.rsp_ready, 1'b0);
      check_eq("rst_port_ready", {ldr_if.req_ready, chk_if.req_ready}, 2'b00);
      check_eq("rst_port_rsp_v", {ldr_if.rsp_valid, chk_if.rsp_valid}, 2'b00);
      @(posedge clk);
      m_q.delete();
      m_pref = 0;
      m_lock = -1;
      m_err  = 1'b0;
      @(negedge clk);
      return;
    end

    full = (m_q.size() == MAXP);
    if (m_lock >= 0) begin
      g = m_lock;
    end else begin
      c0 = rq_v[0] && !(rq_rw[0] == MEM_RW_READ && full);
      c1 = rq_v[1] && !(rq_rw[1] == MEM_RW_READ && full);
`ifdef TB_MEM_ARB_LDR_PRIO_EN
      g = c0 ? 0 : (c1 ? 1 : -1);
`else
      g = (c0 && c1) ? m_pref : (c0 ? 0 : (c1 ? 1 : -1));
`endif
    end

    check_eq("req_valid", mem_if.req_valid, g >= 0);
    if (g >= 0) begin
      check_eq("req_fields",
               {mem_if.req_rw, mem_if.req_addr, mem_if.req_data, mem_if.req_tag},
               {rq_rw[g], rq_addr[g], rq_data[g], rq_tag[g]});
    end
    check_eq("ldr_req_ready", ldr_if.req_ready, g == 0 && m_req_rdy);
    check_eq("chk_req_ready", chk_if.req_ready, g == 1 && m_req_rdy);

    if (m_q.size() == 0) begin
      check_eq("rsp_drop_ready", mem_if.rsp_ready, 1'b1);
      check_eq("rsp_none", {ldr_if.rsp_valid, chk_if.rsp_valid}, 2'b00);
      pop = 1'b0;
      if (m_rsp_v) m_err = 1'b1;
    end else begin
      h = int'(m_q[0]);
      check_eq("ldr_rsp_valid", ldr_if.rsp_valid, m_rsp_v && h == 0);
      check_eq("chk_rsp_valid", chk_if.rsp_valid, m_rsp_v && h == 1);
      check_eq("mem_rsp_ready", mem_if.rsp_ready, p_rsp_rdy[h]);
      if (m_rsp_v) begin
        if (h == 0) check_eq("rsp_payload", {ldr_if.rsp_data, ldr_if.rsp_tag}, {m_rsp_d, m_rsp_t});
        else        check_eq("rsp_payload", {chk_if.rsp_data, chk_if.rsp_tag}, {m_rsp_d, m_rsp_t});
      end
      pop = m_rsp_v && p_rsp_rdy[h];
    end

    hs = (g >= 0) && m_req_rdy;
    @(posedge clk);
    if (pop) void'(m_q.pop_front());
    if (hs) begin
      if (rq_rw[g] == MEM_RW_READ) m_q.push_back(g == 1);
      rq_v[g] = 1'b0;
      m_lock  = -1;
`ifdef TB_MEM_ARB_LDR_PRIO_EN
      m_pref  = 0;
`else
      m_pref  = 1 - g;
`endif
    end else if (g >= 0) begin
      m_lock = g;
    end
    @(negedge clk);
    check_eq("pending_cnt", pending_cnt, m_q.size());
    check_eq("arb_err", arb_err, m_err);
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    rq_v[0] = 1'b0;
    rq_v[1] = 1'b0;
    m_rsp_v = 1'b0;
    cycle();
    reset   = 1'b1;
  endtask

  initial begin
    int exp_g;
    reset        = 1'b0;
    m_req_rdy    = 1'b0;
    m_rsp_d      = '0;
    m_rsp_t      = '0;
    p_rsp_rdy[0] = 1'b0;
    p_rsp_rdy[1] = 1'b0;
    m_pref       = 0;
    m_lock       = -1;
    m_err        = 1'b0;
    for (int p = 0; p < 2; p++) begin
      rq_rw[p] = 1'b0; rq_addr[p] = '0; rq_data[p] = '0; rq_tag[p] = '0;
    end
    @(negedge clk);
    do_reset();
    cycle();
    check_eq("reset_pending", pending_cnt, 3'd0);
    check_eq("reset_err", arb_err, 1'b0);

    // Loader writes 3 lines back to back.
    m_req_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(0, MEM_RW_WRITE, 32'h8000_0000 + i);
      cycle();
      check_eq("ldr_b2b_gnt", obs_gnt, 0);
      check_eq("ldr_b2b_pend", pending_cnt, 3'd0);
    end

    // Both ports contend every cycle.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      issue(0, MEM_RW_WRITE, 32'h8000_0100 + i);
      issue(1, MEM_RW_READ, 32'h8000_0200 + i);
      cycle();
`ifdef TB_MEM_ARB_LDR_PRIO_EN
      exp_g = 0;
`else
      exp_g = i % 2;
`endif
      check_eq("contend_gnt", obs_gnt, exp_g);
    end

    // Checker grant held across 3 stalled cycles while the loader waits.
    do_reset();
    m_req_rdy = 1'b0;
    issue(1, MEM_RW_READ, 32'h8000_0300);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_eq("hold_gnt", obs_gnt, 1);
      check_eq("hold_addr", mem_if.req_addr, 32'h8000_0300);
      issue(0, MEM_RW_WRITE, 32'h8000_0400);
    end
    m_req_rdy = 1'b1;
    cycle();
    check_eq("hold_release", obs_gnt, 1);
    cycle();
    check_eq("hold_next_ldr", obs_gnt, 0);

    // Fill the pending queue, then check read blocking and response routing.
    do_reset();
    for (int i = 0; i < MAXP; i++) begin
      issue(1, MEM_RW_READ, 32'h8000_0500 + i);
      cycle();
    end
    check_eq("full_pending", pending_cnt, 3'd4);
    issue(1, MEM_RW_READ, 32'h8000_0600);
    issue(0, MEM_RW_WRITE, 32'h8000_0700);
    cycle();
    check_eq("full_ldr_gnt", obs_gnt, 0);
    cycle();
    check_eq("full_read_blocked", obs_gnt, -1);
    m_rsp_v      = 1'b1;
    m_rsp_d      = 64'hdead_beef_0123_4567;
    m_rsp_t      = 8'h5a;
    p_rsp_rdy[1] = 1'b1;
    cycle();
    check_eq("full_rsp_port", obs_rsp, 1);
    check_eq("full_blocked_on_pop", obs_gnt, -1);
    check_eq("full_after_pop", pending_cnt, 3'd3);
    m_rsp_v = 1'b0;
    cycle();

    // Orphan response sets the sticky error; reset clears it.
    do_reset();
    m_rsp_v = 1'b1;
    cycle();
    m_rsp_v = 1'b0;
    check_eq("err_set", arb_err, 1'b1);
    cycle();
    cycle();
    check_eq("err_sticky", arb_err, 1'b1);
    do_reset();
    check_eq("err_cleared", arb_err, 1'b0);
    check_eq("err_rst_pending", pending_cnt, 3'd0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 2) == 0)
          issue(0, ($urandom_range(0, 3) == 0) ? MEM_RW_READ : MEM_RW_WRITE, $urandom);
        if ($urandom_range(0, 2) == 0)
          issue(1, ($urandom_range(0, 4) == 0) ? MEM_RW_WRITE : MEM_RW_READ, $urandom);
        m_req_rdy    = ($urandom_range(0, 2) != 0);
        m_rsp_v      = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
        m_rsp_d      = {$urandom, $urandom};
        m_rsp_t      = 8'($urandom);
        p_rsp_rdy[0] = ($urandom_range(0, 2) != 0);
        p_rsp_rdy[1] = ($urandom_range(0, 2) != 0);
        cycle();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vx_tb_mem_arbiter.md
# vx_tb_mem_arbiter

Testbench-side arbiter that shares the single memory-model bus between two requesters: the program/data loader (port 0, write traffic) and the readback checker (port 1, read traffic). It selects one request per cycle, holds the grant stable until the request handshakes, and routes each read response back to the port that issued it. It sits between the memory loader and the memory model in the tb memory subsystem.

## Interface
- MAX_PENDING, default 4: outstanding reads tracked; power of two, ≥2.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- ldr_bus_if  VX_mem_bus_if.slave  —  requester 0 (loader).
- chk_bus_if  VX_mem_bus_if.slave  —  requester 1 (checker).
- mem_bus_if  VX_mem_bus_if.master  —  downstream memory-model bus.
- arb_err  out  1  sticky: a response arrived with no pending read.
- pending_cnt  out  $clog2(MAX_PENDING)+1  reads outstanding.

## Operation
- States: ARB_IDLE, ARB_HOLD.
- ARB_IDLE: the candidate set is the requesters with req_valid, excluding reads when the pending queue is full. Round-robin pick starts at rr_ptr. The granted port's req_data passes combinationally to mem_bus_if; mem_bus_if.req_valid=1.
  - If mem_bus_if.req_ready=1, the request is accepted: stay in ARB_IDLE and set rr_ptr to the other port.
  - Otherwise go to ARB_HOLD with the grant latched.
- ARB_HOLD: the latched port is forwarded regardless of the other port's valid. On handshake, return to ARB_IDLE and set rr_ptr to the other port.
  - If the latched requester drops req_valid, return to ARB_IDLE with no handshake. This is a protocol violation, but the arbiter must not hang on it.
- Ungranted ports see req_ready=0. The granted port's req_ready equals mem_bus_if.req_ready.
- Accepted read (rw=READ): push the source id (1 bit) into the pending queue. Accepted writes push nothing; the memory model returns no write response.
- Response: mem_bus_if.rsp_valid/rsp_data are forwarded to the port at the head of the queue. mem_bus_if.rsp_ready is that port's rsp_ready. The queue pops on rsp handshake.
- Response with an empty queue: set arb_err=1, drop the response with mem_bus_if.rsp_ready=1, and change no other state.
- Queue full: reads are excluded from arbitration even if a pop occurs in the same cycle. Writes still arbitrate.
- Push and pop in the same cycle: pending_cnt is unchanged and order is preserved.
- Tag, address and data pass through unmodified. Width checks are against the VX_mem_bus_if parameters of all three ports, which must match.

## Timing
- Request path: zero added latency (combinational mux of a registered grant/state).
- Response path: zero added latency.
- Reset values: state=ARB_IDLE, rr_ptr=0, queue empty, pending_cnt=0, arb_err=0, all req_ready/rsp_valid outputs 0. mem_bus_if.req_valid=0 and mem_bus_if.rsp_ready=0 while reset is asserted.
- Reset mid-operation: an in-flight grant and the pending queue are discarded. The memory model shares the same reset, so no stale responses are expected.
- Each port makes at most one handshake per cycle, and only one port can handshake per cycle.

## Configuration
- TB_MEM_ARB_LDR_PRIO_EN defined: fixed priority, port 0 (loader) always wins in ARB_IDLE; rr_ptr is unused and held at 0.
- Macro undefined: round-robin as described above.
- Hold/lock behaviour is identical in both modes.

## Structure
- Shared package VX_tb_common_pkg holds:
  - typedef arb_state_t (ARB_IDLE, ARB_HOLD);
  - localparams ARB_PORT_LDR=0 and ARB_PORT_CHK=1.
- Sub-module vx_tb_arb_src_fifo: MAX_PENDING×1-bit FIFO with push, pop, full, empty and count outputs.

## Test plan
- Loader writes 3 lines to addresses 0x80000000+0..2 with req_ready=1 and the checker idle -> 3 back-to-back grants to port 0, pending_cnt stays 0.
- Both ports valid every cycle with req_ready=1 (round-robin build) -> grants alternate 1st=port 0, then 1, 0, 1.
- Checker read with req_ready held 0 for 3 cycles while the loader raises valid -> port 1 grant and req_data stay stable; the loader is granted on the cycle after the handshake.
- 4 checker reads accepted with no response (MAX_PENDING=4) -> pending_cnt=4, 5th read blocked, loader write still granted. Then return 1 response -> routed to port 1, pending_cnt=3.
- Drive mem rsp_valid with the queue empty -> arb_err=1 and held. Then reset low for 1 cycle -> arb_err=0, pending_cnt=0, state=ARB_IDLE.
- Same build as the round-robin case but with TB_MEM_ARB_LDR_PRIO_EN defined, both ports valid for 4 cycles -> port 0 granted all 4 cycles.
